// File: rtl/cfg_mstr_pkg.sv
// Shared definitions for the serial configuration master.
//   state_e     : master FSM states
//   *Def        : default frame geometry and response timeout
//   cnt_w()     : counter width for a counter that must hold the value v
package cfg_mstr_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSend,
        StWaitTx,
        StRecv,
        StDone
    } state_e;

    localparam int unsigned CmdBytesDef = 3;
    localparam int unsigned RspBytesDef = 2;
    localparam int unsigned ToCyclesDef = 65535;

    function automatic int unsigned cnt_w(input int unsigned v);
        return $clog2(v) + 1;
    endfunction

endpackage

// File: rtl/cfg_mstr_gen_uart.sv
// 8N1 UART shared by the configuration link masters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   trmt_i       : one-cycle request to transmit tx_data_i
//   tx_data_i    : byte to send (LSB first on the wire)
//   tx_done_o    : one-cycle pulse when the stop bit has been sent
//   tx_o         : serial out, idles high
//   rx_i         : serial in (asynchronous, synchronised here)
//   rx_data_o    : last received byte
//   rdy_o        : received byte available, held until clr_rdy_i
//   clr_rdy_i    : discard the received byte
module cfg_mstr_gen_uart #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_done_o,
    output logic       tx_o,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rdy_o,
    input  logic       clr_rdy_i
);

    localparam int unsigned BaudW = $clog2(BAUD_DIV + BAUD_DIV / 2) + 1;

    logic [9:0]       tx_shft_q;
    logic             tx_busy_q;
    logic [BaudW-1:0] tx_baud_q;
    logic [3:0]       tx_bit_q;
    logic             tx_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft_q <= '1;
            tx_busy_q <= 1'b0;
            tx_baud_q <= '0;
            tx_bit_q  <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (trmt_i) begin
                tx_shft_q <= {1'b1, tx_data_i, 1'b0};
                tx_busy_q <= 1'b1;
                tx_baud_q <= '0;
                tx_bit_q  <= '0;
            end else if (tx_busy_q) begin
                if (tx_baud_q == BaudW'(BAUD_DIV - 1)) begin
                    tx_baud_q <= '0;
                    tx_shft_q <= {1'b1, tx_shft_q[9:1]};
                    if (tx_bit_q == 4'd9) begin
                        tx_busy_q <= 1'b0;
                        tx_done_q <= 1'b1;
                        tx_bit_q  <= '0;
                    end else begin
                        tx_bit_q <= tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_baud_q <= tx_baud_q + 1'b1;
                end
            end
        end
    end

    assign tx_o      = tx_shft_q[0];
    assign tx_done_o = tx_done_q;

    logic             rx_s1_q, rx_s2_q;
    logic             rx_busy_q;
    logic [BaudW-1:0] rx_baud_q;
    logic [3:0]       rx_bit_q;
    logic [7:0]       rx_shft_q;
    logic             rdy_q;

    // Samples are taken mid-bit; the ninth sample is the stop bit, so the
    // receiver only returns to hunting once the line is back high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_busy_q <= 1'b0;
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
            rx_shft_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            if (!rx_busy_q) begin
                if (!rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BaudW'(BAUD_DIV + BAUD_DIV / 2 - 1);
                    rx_bit_q  <= '0;
                end
            end else if (rx_baud_q == '0) begin
                rx_baud_q <= BaudW'(BAUD_DIV - 1);
                rx_bit_q  <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd8) begin
                    rx_busy_q <= 1'b0;
                end else begin
                    rx_shft_q <= {rx_s2_q, rx_shft_q[7:1]};
                end
            end else begin
                rx_baud_q <= rx_baud_q - 1'b1;
            end

            if (rx_busy_q && rx_baud_q == '0 && rx_bit_q == 4'd8) begin
                rdy_q <= 1'b1;
            end else if (clr_rdy_i) begin
                rdy_q <= 1'b0;
            end
        end
    end

    assign rx_data_o = rx_shft_q;
    assign rdy_o     = rdy_q;

endmodule

// File: rtl/cfg_mstr_gen.sv
// Configuration master: sends a CMD_BYTES command frame (top byte first) over
// the UART, then collects RSP_BYTES response bytes into resp.
//   clk, rst_n : clock, asynchronous active-low reset
//   snd_frm    : start request, accepted only when idle or done
//   cmd_data   : command, captured on acceptance
//   resp       : last complete response, first byte in the top bits
//   rsp_rdy    : resp valid, sticky until the next accepted request
//   busy       : frame in progress
//   timeout    : last frame aborted waiting for a response byte, sticky
//   TX_C, RX_C : UART serial out / in
// BAUD_DIV sets clocks per UART bit.
// Define CFG_MSTR_GEN_CHKSUM_EN to append an inverted 8-bit sum of the command
// bytes as an extra byte after the command.
module cfg_mstr_gen
    import cfg_mstr_pkg::*;
#(
    parameter int unsigned CMD_BYTES = CmdBytesDef,
    parameter int unsigned RSP_BYTES = RspBytesDef,
    parameter int unsigned TO_CYCLES = ToCyclesDef,
    parameter int unsigned BAUD_DIV  = 434
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snd_frm,
    input  logic [8*CMD_BYTES-1:0] cmd_data,
    output logic [8*RSP_BYTES-1:0] resp,
    output logic                   rsp_rdy,
    output logic                   busy,
    output logic                   timeout,
    output logic                   TX_C,
    input  logic                   RX_C
);

    localparam int unsigned IdxW = cnt_w(CMD_BYTES);
    localparam int unsigned RxW  = cnt_w(RSP_BYTES);
    localparam int unsigned ToW  = cnt_w(TO_CYCLES);

    state_e                 state_q;
    logic [8*CMD_BYTES-1:0] shadow_q;
    logic [IdxW-1:0]        idx_q;
    logic [RxW-1:0]         rx_cnt_q;
    logic [ToW-1:0]         to_cnt_q;
    logic [8*RSP_BYTES-1:0] acc_q;
    logic [8*RSP_BYTES-1:0] resp_q;
    logic                   rsp_rdy_q;
    logic                   busy_q;
    logic                   timeout_q;
    logic                   trmt_q;
    logic [7:0]             tx_data_q;

    logic                   tx_done;
    logic                   rdy;
    logic                   clr_rdy;
    logic [7:0]             rx_data;
    logic [7:0]             cmd_byte;
    logic [7:0]             next_byte;
    logic                   last_byte;
    logic [8*RSP_BYTES-1:0] acc_shift;

    assign cmd_byte = shadow_q[8*int'(idx_q) +: 8];

`ifdef CFG_MSTR_GEN_CHKSUM_EN
    logic       chk_q;
    logic [7:0] chk_sum;

    always_comb begin
        chk_sum = 8'h00;
        for (int i = 0; i < int'(CMD_BYTES); i++) begin
            chk_sum = chk_sum + shadow_q[8*i +: 8];
        end
    end

    assign next_byte = chk_q ? ~chk_sum : cmd_byte;
    assign last_byte = chk_q;
`else
    assign next_byte = cmd_byte;
    assign last_byte = (idx_q == '0);
`endif

    always_comb begin
        acc_shift      = acc_q << 8;
        acc_shift[7:0] = rx_data;
    end

    // Clearing on RECV entry drops any byte that arrived while transmitting.
    assign clr_rdy = (state_q == StWaitTx && tx_done && last_byte) ||
                     (state_q == StRecv && rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            idx_q     <= '0;
            rx_cnt_q  <= '0;
            to_cnt_q  <= '0;
            acc_q     <= '0;
            resp_q    <= '0;
            rsp_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            trmt_q    <= 1'b0;
            tx_data_q <= '0;
`ifdef CFG_MSTR_GEN_CHKSUM_EN
            chk_q     <= 1'b0;
`endif
        end else begin
            trmt_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (snd_frm) begin
                        shadow_q  <= cmd_data;
                        idx_q     <= IdxW'(CMD_BYTES - 1);
                        rsp_rdy_q <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StLoad;
`ifdef CFG_MSTR_GEN_CHKSUM_EN
                        chk_q     <= 1'b0;
`endif
                    end
                end
                StLoad, StSend: begin
                    trmt_q    <= 1'b1;
                    tx_data_q <= next_byte;
                    state_q   <= StWaitTx;
                end
                StWaitTx: begin
                    if (tx_done) begin
                        if (last_byte) begin
                            to_cnt_q <= ToW'(TO_CYCLES);
                            rx_cnt_q <= '0;
                            acc_q    <= '0;
                            state_q  <= StRecv;
                        end else begin
`ifdef CFG_MSTR_GEN_CHKSUM_EN
                            if (idx_q == '0) begin
                                chk_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q - 1'b1;
                            end
`else
                            idx_q <= idx_q - 1'b1;
`endif
                            state_q <= StSend;
                        end
                    end
                end
                StRecv: begin
                    // A byte arriving as the counter expires still counts.
                    if (rdy) begin
                        acc_q    <= acc_shift;
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                        to_cnt_q <= ToW'(TO_CYCLES);
                        if (rx_cnt_q == RxW'(RSP_BYTES - 1)) begin
                            resp_q    <= acc_shift;
                            rsp_rdy_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= StDone;
                        end
                    end else if (to_cnt_q <= ToW'(1)) begin
                        to_cnt_q  <= '0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp    = resp_q;
    assign rsp_rdy = rsp_rdy_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

    cfg_mstr_gen_uart #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .trmt_i   (trmt_q),
        .tx_data_i(tx_data_q),
        .tx_done_o(tx_done),
        .tx_o     (TX_C),
        .rx_i     (RX_C),
        .rx_data_o(rx_data),
        .rdy_o    (rdy),
        .clr_rdy_i(clr_rdy)
    );

endmodule
